// File: rtl/pwm_signal_gen.sv
// ----------------------------------------------------------------------------
// pwm_signal_gen
//
// Programmable square/PWM waveform generator. Emits a waveform whose period
// and high time are given in system-clock cycles. It runs either for a fixed
// number of periods (burst) or continuously until a graceful stop is
// requested. It is the stimulus counterpart of the frequency/duty measurement
// block and can feed it directly for loopback self-test.
//
// Parameters
//   CNT_W    width of the period / high-time counters
//   BURST_W  width of the burst count
//
// Ports
//   clk_i          system clock
//   rst_i          synchronous reset, active-high
//   enable_i       start request, only looked at while idle
//   stop_i         graceful stop request, only looked at while busy
//   period_i       period in clock cycles (0 is rejected with cfg_err_o)
//   high_time_i    high cycles per period (0 = always low, >= period = always high)
//   burst_i        number of periods to emit, 0 = continuous
//   sig_out_o      generated waveform, registered
//   busy_o         high while generating
//   period_done_o  one-cycle pulse in the last cycle of every period
//   finish_o       one-cycle pulse in the first idle cycle after a normal end
//   cfg_err_o      one-cycle pulse one cycle after a zero period was sampled
// ----------------------------------------------------------------------------
module pwm_signal_gen #(
   parameter int CNT_W   = 20,
   parameter int BURST_W = 16
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               enable_i,
   input  logic               stop_i,
   input  logic [CNT_W-1:0]   period_i,
   input  logic [CNT_W-1:0]   high_time_i,
   input  logic [BURST_W-1:0] burst_i,
   output logic               sig_out_o,
   output logic               busy_o,
   output logic               period_done_o,
   output logic               finish_o,
   output logic               cfg_err_o
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   state_e state_q, state_d;

   // Shadow configuration, only ever updated on a period boundary so the
   // waveform never changes shape in the middle of a period.
   logic [CNT_W-1:0]   period_q, period_d;
   logic [CNT_W-1:0]   high_q, high_d;
   logic [BURST_W-1:0] burst_q, burst_d;

   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [BURST_W-1:0] nper_q, nper_d;
   logic               stopSeen_q, stopSeen_d;

   logic               sig_q, sig_d;
   logic               finish_q, finish_d;
   logic               cfgErr_q, cfgErr_d;

   logic               startReq;
   logic               lastCycle;
   logic               endRun;
   logic [BURST_W-1:0] nperNext;

   // A start is only considered when idle with enable and no concurrent stop;
   // enable together with stop is deliberately a no-op (no start, no error).
   assign startReq  = (state_q == IDLE) && enable_i && !stop_i;
   assign lastCycle = (state_q == RUN) && (cnt_q == (period_q - CNT_W'(1)));
   assign nperNext  = nper_q + BURST_W'(1);

   // The run ends at a period boundary when the burst count is reached or a
   // stop has been requested at any time during the run (including the
   // boundary cycle itself), so a stop coinciding with a natural burst end
   // still yields a single finish pulse.
   assign endRun = lastCycle &&
                   (((burst_q != '0) && (nperNext == burst_q)) || stopSeen_q || stop_i);

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: a legal start enters RUN, an end condition returns to IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (startReq && (period_i != '0)) state_d = RUN;
         RUN:  if (endRun) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs derived directly from the state and counter registers.
   always_comb begin
      busy_o        = (state_q == RUN);
      period_done_o = lastCycle;
      sig_out_o     = sig_q;
      finish_o      = finish_q;
      cfg_err_o     = cfgErr_q;
   end

   // Datapath next-state logic. The waveform bit is computed one cycle ahead
   // from the counter value of the coming cycle so sig_out can be a plain
   // register. Comparing cnt against high naturally clamps high >= period to
   // a constant high level.
   always_comb begin
      period_d   = period_q;
      high_d     = high_q;
      burst_d    = burst_q;
      cnt_d      = cnt_q;
      nper_d     = nper_q;
      stopSeen_d = stopSeen_q;
      sig_d      = 1'b0;
      finish_d   = 1'b0;
      cfgErr_d   = 1'b0;
      case (state_q)
         IDLE: begin
            stopSeen_d = 1'b0;
            if (startReq) begin
               if (period_i == '0) begin
                  cfgErr_d = 1'b1;
               end else begin
                  period_d = period_i;
                  high_d   = high_time_i;
                  burst_d  = burst_i;
                  cnt_d    = '0;
                  nper_d   = '0;
                  sig_d    = (high_time_i != '0);
               end
            end
         end
         RUN: begin
            stopSeen_d = stopSeen_q || stop_i;
            if (lastCycle) begin
               cnt_d  = '0;
               nper_d = nperNext;
               if (endRun) begin
                  finish_d   = 1'b1;
                  stopSeen_d = 1'b0;
               end else if (period_i != '0) begin
                  // Burst length is fixed for the run; only shape reloads.
                  period_d = period_i;
                  high_d   = high_time_i;
                  sig_d    = (high_time_i != '0);
               end else begin
                  cfgErr_d = 1'b1;
                  sig_d    = (high_q != '0);
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               sig_d = ((cnt_q + CNT_W'(1)) < high_q);
            end
         end
         default: ;
      endcase
   end

   // Datapath registers; reset clears every flag and output, so a reset in
   // the middle of a run never produces a finish pulse.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         period_q   <= '0;
         high_q     <= '0;
         burst_q    <= '0;
         cnt_q      <= '0;
         nper_q     <= '0;
         stopSeen_q <= 1'b0;
         sig_q      <= 1'b0;
         finish_q   <= 1'b0;
         cfgErr_q   <= 1'b0;
      end else begin
         period_q   <= period_d;
         high_q     <= high_d;
         burst_q    <= burst_d;
         cnt_q      <= cnt_d;
         nper_q     <= nper_d;
         stopSeen_q <= stopSeen_d;
         sig_q      <= sig_d;
         finish_q   <= finish_d;
         cfgErr_q   <= cfgErr_d;
      end
   end

endmodule
